// File: rtl/screen_scanout.sv
// screen_scanout: 32x32 1-bit frame capture into a shadow register and
// row-by-row serial refresh of a shift-register LED matrix.
module screen_scanout #(
  parameter int unsigned CLK_DIV     = 1,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic [1023:0] frame_in,
  input  logic          frame_valid,
  output logic          frame_ready,
  output logic          frame_done,
  output logic          sclk,
  output logic          sdata,
  output logic          row_latch,
  output logic [4:0]    row_sel,
  output logic          blank
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_LATCH = 3'd2,
    S_HOLD  = 3'd3,
    S_WRAP  = 3'd4
  } state_e;

  state_e              state_q;
  logic [1023:0]       shadow_q;
  logic [4:0]          row_q;
  logic [4:0]          col_q;
  logic [DIV_W-1:0]    div_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                frame_ready_q;
  logic                frame_done_q;
  logic                sclk_q;
  logic                sdata_q;
  logic                row_latch_q;
  logic [4:0]          row_sel_q;
  logic                blank_q;

  logic                accept;
  logic [4:0]          row_inc;
  logic [4:0]          col_dec;

  // Handshake and counter neighbours used by the sequencer.
  assign accept  = frame_valid & frame_ready_q;
  assign row_inc = row_q + 5'd1;
  assign col_dec = col_q - 5'd1;

  // Scan sequencer: state, counters, shadow frame and all registered outputs.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      shadow_q      <= '0;
      row_q         <= 5'd0;
      col_q         <= 5'd0;
      div_q         <= '0;
      hold_q        <= '0;
      frame_ready_q <= 1'b1;
      frame_done_q  <= 1'b0;
      sclk_q        <= 1'b0;
      sdata_q       <= 1'b0;
      row_latch_q   <= 1'b0;
      row_sel_q     <= 5'd0;
      blank_q       <= 1'b1;
    end else begin
      frame_done_q <= 1'b0;
      row_latch_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            shadow_q      <= frame_in;
            sdata_q       <= frame_in[31];
            row_q         <= 5'd0;
            col_q         <= 5'd31;
            div_q         <= '0;
            sclk_q        <= 1'b0;
            frame_ready_q <= 1'b0;
            state_q       <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (div_q != DIV_LAST) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else if (col_q == 5'd0) begin
              sclk_q      <= 1'b0;
              row_latch_q <= 1'b1;
              state_q     <= S_LATCH;
            end else begin
              sclk_q  <= 1'b0;
              col_q   <= col_dec;
              sdata_q <= shadow_q[{row_q, col_dec}];
            end
          end
        end
        S_LATCH: begin
          blank_q   <= 1'b0;
          row_sel_q <= row_q;
          hold_q    <= '0;
          state_q   <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_q != HOLD_LAST) begin
            hold_q <= hold_q + HOLD_W'(1);
          end else if (row_q == 5'd31) begin
            blank_q       <= 1'b1;
            frame_done_q  <= 1'b1;
            frame_ready_q <= 1'b1;
            state_q       <= S_WRAP;
          end else begin
            blank_q <= 1'b1;
            row_q   <= row_inc;
            col_q   <= 5'd31;
            div_q   <= '0;
            sdata_q <= shadow_q[{row_inc, 5'd31}];
            state_q <= S_SHIFT;
          end
        end
        S_WRAP: begin
          // A frame offered here replaces the shadow before the next scan.
          if (accept) begin
            shadow_q <= frame_in;
            sdata_q  <= frame_in[31];
          end else begin
            sdata_q  <= shadow_q[31];
          end
          row_q         <= 5'd0;
          col_q         <= 5'd31;
          div_q         <= '0;
          sclk_q        <= 1'b0;
          frame_ready_q <= 1'b0;
          state_q       <= S_SHIFT;
        end
        default: begin
          state_q       <= S_IDLE;
          frame_ready_q <= 1'b1;
          blank_q       <= 1'b1;
          sclk_q        <= 1'b0;
        end
      endcase
    end
  end

  assign frame_ready = frame_ready_q;
  assign frame_done  = frame_done_q;
  assign sclk        = sclk_q;
  assign sdata       = sdata_q;
  assign row_latch   = row_latch_q;
  assign row_sel     = row_sel_q;
  assign blank       = blank_q;

endmodule

// File: tb/tb_screen_scanout.sv
// Bench for screen_scanout: per-cycle comparison against an arithmetic model
// of the scan timeline, with a default instance and a CLK_DIV=2/HOLD=1 one.
module tb_screen_scanout;

  localparam int P0 = 32 * (64 * 1 + 1 + 4) + 1;  // 2209
  localparam int R1 = 64 * 2 + 1 + 1;             // 130
  localparam int P1 = 32 * R1 + 1;                // 4161
  localparam logic [10:0] RST_OUT = 11'b100_0000_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic [1023:0] fin0, fin1;
  logic          fv0, fv1;
  logic          rdy0, done0, sclk0, sd0, lat0, blk0;
  logic          rdy1, done1, sclk1, sd1, lat1, blk1;
  logic [4:0]    sel0, sel1;

  int errors = 0;
  int checks = 0;

  logic [1023:0] g_frame;
  int            g_k;
  logic          scan1_q[$];

  screen_scanout dut0 (
    .clkin(clk), .rst(rst), .frame_in(fin0), .frame_valid(fv0),
    .frame_ready(rdy0), .frame_done(done0), .sclk(sclk0), .sdata(sd0),
    .row_latch(lat0), .row_sel(sel0), .blank(blk0)
  );

  screen_scanout #(.CLK_DIV(2), .HOLD_CYCLES(1)) dut1 (
    .clkin(clk), .rst(rst), .frame_in(fin1), .frame_valid(fv1),
    .frame_ready(rdy1), .frame_done(done1), .sclk(sclk1), .sdata(sd1),
    .row_latch(lat1), .row_sel(sel1), .blank(blk1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packing: {ready, done, sclk, sdata, latch, row_sel[4:0], blank}
  function automatic logic [10:0] out0();
    return {rdy0, done0, sclk0, sd0, lat0, sel0, blk0};
  endfunction

  function automatic logic [10:0] out1();
    return {rdy1, done1, sclk1, sd1, lat1, sel1, blk1};
  endfunction

  function automatic logic [1023:0] rand_frame();
    logic [1023:0] f;
    for (int i = 0; i < 32; i++) f[32*i +: 32] = $urandom;
    return f;
  endfunction

  // Expected outputs k cycles after the capture edge, from the row/bit timeline.
  function automatic logic [10:0] model(input logic [1023:0] f, input int kin,
                                        input int cd, input int hc, input logic [4:0] prev);
    int rt, p, k, j, r, o, b;
    logic [4:0] ps;
    logic hi;
    rt = 64 * cd + 1 + hc;
    p  = 32 * rt + 1;
    k  = kin;
    ps = prev;
    if (k > p) begin
      k  = ((k - 1) % p) + 1;
      ps = 5'd31;
    end
    if (k == p) return {1'b1, 1'b1, 1'b0, f[992], 1'b0, 5'd31, 1'b1};
    j = k - 1;
    r = j / rt;
    o = j % rt;
    if (r != 0) ps = 5'(r - 1);
    if (o < 64 * cd) begin
      b  = o / (2 * cd);
      hi = ((o % (2 * cd)) >= cd);
      return {2'b00, hi, f[32*r + 31 - b], 1'b0, ps, 1'b1};
    end
    if (o == 64 * cd) return {2'b00, 1'b0, f[32*r], 1'b1, ps, 1'b1};
    return {2'b00, 1'b0, f[32*r], 1'b0, 5'(r), 1'b0};
  endfunction

  task automatic test_reset();
    logic [10:0] o, e;
    logic [1023:0] f;
    rst = 1'b1; fv0 = 1'b0; fv1 = 1'b0; fin0 = '0; fin1 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    o = out0();
    checks++;
    if (o !== RST_OUT) begin errors++; $display("FAIL reset_initial got=%h exp=%h", o, RST_OUT); end
    o = out1();
    checks++;
    if (o !== RST_OUT) begin errors++; $display("FAIL reset_initial_div2 got=%h exp=%h", o, RST_OUT); end

    f = rand_frame();
    fin0 = f; fv0 = 1'b1;
    tick();
    fv0 = 1'b0;
    for (int k = 1; k < 550; k++) tick();
    o = out0(); e = model(f, 550, 1, 4, 5'd0);
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_row7_hold got=%h exp=%h", o, e); end

    #2 rst = 1'b1;
    #1 o = out0();
    checks++;
    if (o !== RST_OUT) begin errors++; $display("FAIL reset_async got=%h exp=%h", o, RST_OUT); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      o = out0();
      checks++;
      if (o !== RST_OUT) begin errors++; $display("FAIL reset_idle c=%0d got=%h exp=%h", k, o, RST_OUT); end
    end
  endtask

  task automatic test_single_frame();
    logic [10:0] o, e;
    logic prev_sclk;
    logic [31:0] bits;
    int edges, latch_k, hold_cnt;
    g_frame = '0;
    g_frame[31:0] = 32'h8000_0001;
    fin0 = g_frame; fv0 = 1'b1;
    tick();
    fv0 = 1'b0;
    fin0 = rand_frame();
    prev_sclk = 1'b0; edges = 0; latch_k = -1; hold_cnt = 0; bits = '0;
    scan1_q.delete();
    for (int k = 1; k <= 69; k++) begin
      o = out0(); e = model(g_frame, k, 1, 4, 5'd0);
      checks++;
      if (o !== e) begin errors++; $display("FAIL single_cycle k=%0d got=%h exp=%h", k, o, e); end
      if (o[8] && !prev_sclk) begin
        if (edges < 32) bits[31 - edges] = o[7];
        edges++;
        scan1_q.push_back(o[7]);
      end
      prev_sclk = o[8];
      if (o[6]) latch_k = k;
      if (!o[0] && o[5:1] == 5'd0) hold_cnt++;
      tick();
    end
    g_k = 70;
    checks++;
    if (edges != 32) begin errors++; $display("FAIL single_edges got=%0d exp=32", edges); end
    checks++;
    if (bits[31] !== 1'b1) begin errors++; $display("FAIL single_first_bit got=%b exp=1", bits[31]); end
    checks++;
    if (bits[30:1] !== 30'd0) begin errors++; $display("FAIL single_mid_bits got=%h exp=0", bits[30:1]); end
    checks++;
    if (bits[0] !== 1'b1) begin errors++; $display("FAIL single_last_bit got=%b exp=1", bits[0]); end
    checks++;
    if (latch_k != 65) begin errors++; $display("FAIL single_latch_cycle got=%0d exp=65", latch_k); end
    checks++;
    if (hold_cnt != 4) begin errors++; $display("FAIL single_hold_len got=%0d exp=4", hold_cnt); end
  endtask

  task automatic test_frame_period();
    logic [10:0] o, e;
    logic prev_sclk, ready_at_done;
    logic scan2_q[$];
    int done_first, diffs;
    prev_sclk = 1'b0; done_first = -1; ready_at_done = 1'b0;
    for (int k = g_k; k <= 2 * P0; k++) begin
      o = out0(); e = model(g_frame, k, 1, 4, 5'd0);
      checks++;
      if (o !== e) begin errors++; $display("FAIL period_cycle k=%0d got=%h exp=%h", k, o, e); end
      if (o[8] && !prev_sclk) begin
        if (k <= P0) scan1_q.push_back(o[7]);
        else scan2_q.push_back(o[7]);
      end
      prev_sclk = o[8];
      if (o[9] && done_first < 0) begin done_first = k; ready_at_done = o[10]; end
      tick();
    end
    checks++;
    if (done_first != P0) begin errors++; $display("FAIL period_done got=%0d exp=%0d", done_first, P0); end
    checks++;
    if (ready_at_done !== 1'b1) begin errors++; $display("FAIL period_ready_at_done got=%b exp=1", ready_at_done); end
    checks++;
    if (scan1_q.size() != 1024 || scan2_q.size() != 1024) begin
      errors++; $display("FAIL period_bit_count got=%0d/%0d exp=1024", scan1_q.size(), scan2_q.size());
    end else begin
      diffs = 0;
      for (int i = 0; i < 1024; i++) if (scan1_q[i] !== scan2_q[i]) diffs++;
      if (diffs != 0) begin errors++; $display("FAIL period_repeat_stream got=%0d diffs exp=0", diffs); end
    end
  endtask

  task automatic test_mid_scan();
    logic [10:0] o, e;
    logic [1023:0] a, b;
    logic prev_sclk;
    int early_ready, ones, edges;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    a = rand_frame();
    b = '1;
    fin0 = a; fv0 = 1'b1;
    tick();
    fv0 = 1'b0;
    fin0 = ~a;
    early_ready = 0;
    for (int k = 1; k <= P0; k++) begin
      o = out0(); e = model(a, k, 1, 4, 5'd0);
      checks++;
      if (o !== e) begin errors++; $display("FAIL midscan_a k=%0d got=%h exp=%h", k, o, e); end
      if (k < P0 && o[10]) early_ready++;
      if (k == P0) begin
        checks++;
        if (o[10] !== 1'b1) begin errors++; $display("FAIL midscan_wrap_ready got=%b exp=1", o[10]); end
      end
      if (k == 10 * 69 + 1) begin fin0 = b; fv0 = 1'b1; end
      tick();
    end
    fv0 = 1'b0;
    checks++;
    if (early_ready != 0) begin errors++; $display("FAIL midscan_early_ready got=%0d exp=0", early_ready); end
    prev_sclk = 1'b0; ones = 0; edges = 0;
    for (int k = 1; k <= P0; k++) begin
      o = out0(); e = model(b, k, 1, 4, 5'd31);
      checks++;
      if (o !== e) begin errors++; $display("FAIL midscan_b k=%0d got=%h exp=%h", k, o, e); end
      if (o[8] && !prev_sclk) begin edges++; if (o[7]) ones++; end
      prev_sclk = o[8];
      tick();
    end
    checks++;
    if (ones != 1024 || edges != 1024) begin
      errors++; $display("FAIL midscan_b_ones got=%0d of %0d exp=1024", ones, edges);
    end
  endtask

  task automatic test_div2();
    logic [10:0] o, e;
    logic [1023:0] f;
    logic prev_sclk;
    int edges, last_edge, bad_gap, zeros, sel31, latch30, latch31, lo, hi;
    f = rand_frame();
    f[1023:992] = 32'hFFFF_FFFF;
    fin1 = f; fv1 = 1'b1;
    tick();
    fv1 = 1'b0;
    lo = 31 * R1 + 1;
    hi = 32 * R1;
    prev_sclk = 1'b0; edges = 0; last_edge = -1; bad_gap = 0; zeros = 0; sel31 = 0;
    latch30 = -1; latch31 = -1;
    for (int k = 1; k <= P1; k++) begin
      o = out1(); e = model(f, k, 2, 1, 5'd0);
      checks++;
      if (o !== e) begin errors++; $display("FAIL div2_cycle k=%0d got=%h exp=%h", k, o, e); end
      if (o[6]) begin
        if (k > 30 * R1 && k <= 31 * R1) latch30 = k;
        if (k >= lo && k <= hi) latch31 = k;
      end
      if (k >= lo && k <= hi) begin
        if (o[8] && !prev_sclk) begin
          edges++;
          if (last_edge >= 0 && k - last_edge != 4) bad_gap++;
          last_edge = k;
        end
        if (k < lo + 128 && !o[7]) zeros++;
        if (o[5:1] == 5'd31 && !o[0]) sel31++;
      end
      prev_sclk = o[8];
      tick();
    end
    checks++;
    if (edges != 32) begin errors++; $display("FAIL div2_edges got=%0d exp=32", edges); end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL div2_sclk_period got=%0d bad exp=0", bad_gap); end
    checks++;
    if (zeros != 0) begin errors++; $display("FAIL div2_sdata_ones got=%0d zeros exp=0", zeros); end
    checks++;
    if (latch31 - latch30 != R1) begin
      errors++; $display("FAIL div2_row_time got=%0d exp=%0d", latch31 - latch30, R1);
    end
    checks++;
    if (sel31 != 1) begin errors++; $display("FAIL div2_hold_len got=%0d exp=1", sel31); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_frame_period();
    test_mid_scan();
    test_div2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/screen_scanout.md
# screen_scanout

Display scan-out engine for the BatPU screen path. It accepts a complete 32x32 1-bit frame from the CPU's screen buffer through a valid/ready handshake and holds it in a shadow register. It then refreshes an external shift-register LED matrix row by row, driving serial clock, data, latch, row select and blank. The CPU writes frames; this block reads and displays them continuously until a new frame is accepted.

## Interface
Parameters:
- CLK_DIV, default 1: system clocks per half serial-clock period; minimum 1.
- HOLD_CYCLES, default 4: clocks each row is displayed (blank low); minimum 1.

Ports:
- clkin  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- frame_in  input  1024  frame to display; row r is bits [32r+31:32r], column c is bit 32r+c.
- frame_valid  input  1  producer has a frame on frame_in; held until accepted.
- frame_ready  output  1  block can accept a frame this cycle.
- frame_done  output  1  one-cycle pulse when row 31's hold period completes.
- sclk  output  1  serial shift clock to the matrix.
- sdata  output  1  serial pixel data; sampled by the matrix on the rising edge of sclk.
- row_latch  output  1  one-cycle pulse that transfers the shifted row into the matrix output register.
- row_sel  output  5  row currently being displayed.
- blank  output  1  high disables matrix drivers.

## Operation
- All outputs are registered. The values listed for a state are the values visible during that state's cycles.
- States:
  - IDLE
  - SHIFT
  - LATCH
  - HOLD
  - WRAP
- Accept rule: a frame is accepted when frame_valid and frame_ready are both high at a clkin edge. On acceptance, frame_in is copied to the 1024-bit shadow register and the row counter is set to 0. Later changes to frame_in have no effect.
- frame_ready is high only in IDLE and WRAP.
- IDLE:
  - blank=1, sclk=0, sdata=0, row_latch=0.
  - Stays in IDLE until a frame is accepted, then goes to SHIFT.
- SHIFT:
  - blank=1.
  - Shifts 32 bits of the current row, column 31 first, column 0 last.
  - For each bit: sdata = shadow[32*row + col] with sclk=0 for CLK_DIV cycles, then the same sdata with sclk=1 for CLK_DIV cycles.
  - After column 0's high phase, go to LATCH.
- LATCH:
  - One cycle. sclk=0, row_latch=1, blank=1.
  - Next state is HOLD.
- HOLD:
  - row_sel = current row, blank=0, sclk=0, for HOLD_CYCLES cycles.
  - Then: if row < 31, increment row and go to SHIFT; if row = 31, go to WRAP.
- WRAP:
  - One cycle. blank=1, frame_done=1, frame_ready=1.
  - If a frame is accepted this cycle, the shadow register is replaced. Otherwise the old shadow register is kept.
  - row = 0; next state is SHIFT.
  - The refresh repeats indefinitely.
- The row counter is 5 bits and wraps only through WRAP; it never overflows silently.
- frame_valid outside IDLE/WRAP is ignored. The producer keeps it asserted until it is accepted.

## Timing
- Reset values, effective immediately on rst, including mid-row:
  - frame_ready=1, frame_done=0, sclk=0, sdata=0, row_latch=0, row_sel=0, blank=1.
  - State = IDLE, shadow register = 0, row and column counters = 0.
- Capture latency: in the cycle after the accepting edge, SHIFT begins with sdata = bit 31 of row 0 and sclk=0.
- Per-bit time: 2*CLK_DIV cycles.
- Row time: 64*CLK_DIV + 1 + HOLD_CYCLES cycles.
- Frame period including WRAP: 32*(64*CLK_DIV + 1 + HOLD_CYCLES) + 1 cycles. With the defaults this is 2209.
- sdata changes only in the cycle where sclk goes (or stays) low at the start of a bit. It is stable throughout the high phase.
- row_sel changes only on entry to HOLD. It holds its value through SHIFT, LATCH and WRAP.
- frame_done and frame_ready-in-WRAP occur in the same cycle.

## Test plan
- Reset: assert rst mid-HOLD of row 7. Required: within the same cycle, blank=1, row_sel=0, frame_ready=1, sclk=0. After release, the block stays IDLE with no sclk edges.
- Single frame, defaults, row 0 = 0x80000001, all other rows 0. Required:
  - The first bit after capture has sdata=1; bits 30..1 have sdata=0; the last bit has sdata=1.
  - Exactly 32 sclk rising edges occur.
  - row_latch pulses in cycle 65 after capture.
  - blank is low for 4 cycles with row_sel=0.
- Frame period, defaults, no further frame_valid. Required:
  - frame_done pulses 2209 cycles after the capture edge, together with frame_ready=1.
  - The second scan's sdata stream is identical to the first.
- Mid-scan frame: present frame B (all ones) at row 10 of frame A and hold frame_valid. Also change frame_in on the cycle after A's capture. Required:
  - frame_ready stays low until WRAP, and B is accepted in WRAP.
  - A's scan shows the original A data only.
  - The next scan shows all ones.
- CLK_DIV=2, HOLD_CYCLES=1, row 31 = 0xFFFFFFFF. Required:
  - sclk period is 4 cycles, with 32 rising edges during row 31 and sdata=1 throughout.
  - Row time is 130 cycles.
  - row_sel=31 for exactly 1 cycle with blank=0.
